// File: rtl/pipeline_seq_ctrl_if.sv
// Host/pipeline handshake bundle for the packet-pipeline sequencer.
// master: the host/pipeline side that drives job, packet and status inputs.
// slave:  the sequencer, which drives pipeline controls and packet flow strobes.
interface pipeline_seq_ctrl_if;
    logic       start;
    logic       pkt_in_valid;
    logic       pkt_in_last;
    logic       pkt_in_ready;
    logic       pkt_out_ready;
    logic       pkt_out_valid;
    logic       pkt_out_last;
    logic [7:0] fifo_depth;
    logic [3:0] thread_halt;
    logic [1:0] mode_code;
    logic [1:0] thread_IF;
    logic       pipe_rst;
    logic       rst_FIFO;
    logic       busy;
    logic       done;
    logic       timeout;

    modport master (
        output start, pkt_in_valid, pkt_in_last, pkt_out_ready, fifo_depth, thread_halt,
        input  pkt_in_ready, pkt_out_valid, pkt_out_last, mode_code, thread_IF,
               pipe_rst, rst_FIFO, busy, done, timeout
    );

    modport slave (
        input  start, pkt_in_valid, pkt_in_last, pkt_out_ready, fifo_depth, thread_halt,
        output pkt_in_ready, pkt_out_valid, pkt_out_last, mode_code, thread_IF,
               pipe_rst, rst_FIFO, busy, done, timeout
    );
endinterface

// File: rtl/pipeline_seq_ctrl.sv
// Purpose: sequences one packet job through CLR -> FILL -> RUN -> DRAIN for the 4-thread pipeline.
// Latency: start->CLR 1 cycle, CLR->FILL 1, last word->RUN 1, final read->pkt_out_valid 1->done 1.
// Backpressure: FILL stalls (pkt_in_ready=0) at fifo_depth==FIFO_CAP; DRAIN reads only while pkt_out_ready.
//
// Ports: clk, rst (async, active-high); bus (slave modport) carries start, the packet in/out
// handshakes, fifo_depth, thread_halt and the pipeline controls mode_code, thread_IF, pipe_rst,
// rst_FIFO plus busy/done/timeout status.
// Build option: define THREAD_SKIP_EN to make RUN fetch only non-halted threads.
module pipeline_seq_ctrl #(
    parameter int FIFO_CAP       = 255,
    parameter int MAX_RUN_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input logic                clk,
    input logic                rst,
    pipeline_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CLR, FILL, RUN, DRAIN} state_t;

    localparam logic [7:0]       CAP8     = 8'(FIFO_CAP);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(MAX_RUN_CYCLES - 1);

    state_t           state, state_nxt;
    logic [7:0]       word_cnt, rd_cnt;
    logic [CNT_W-1:0] run_cnt;
    logic [1:0]       thread_q, thr_entry, thr_next;
    logic             out_vld_q, out_last_q, done_q, timeout_q;
    logic             in_rdy, accept, rd_stb, all_halt, run_lim, run_exit, drain_end;
    logic [1:0]       mode_c;
    logic             pipe_rst_c, rst_fifo_c;

    assign in_rdy    = (state == FILL) && (bus.fifo_depth < CAP8);
    assign accept    = in_rdy && bus.pkt_in_valid;
    assign rd_stb    = (state == DRAIN) && bus.pkt_out_ready && (rd_cnt != 8'd0);
    assign all_halt  = (bus.thread_halt == 4'hF);
    assign run_lim   = (run_cnt == RUN_LAST);
    assign run_exit  = all_halt || run_lim;
    // An empty job has nothing to read; otherwise finish once the last word has been presented.
    assign drain_end = (word_cnt == 8'd0) || (out_vld_q && out_last_q);

`ifdef THREAD_SKIP_EN
    // First non-halted thread after cur in round-robin order; cur itself is the last resort.
    // If every thread is halted RUN exits this cycle anyway, so plain rotation is fine.
    function automatic logic [1:0] next_live(input logic [1:0] cur, input logic [3:0] halt);
        logic [1:0] pick;
        logic [1:0] cand;
        pick = cur + 2'd1;
        for (int k = 4; k >= 1; k--) begin
            cand = cur + 2'(k);
            if (!halt[cand]) pick = cand;
        end
        return pick;
    endfunction

    assign thr_entry = next_live(2'd3, bus.thread_halt);
    assign thr_next  = next_live(thread_q, bus.thread_halt);
`else
    assign thr_entry = 2'd0;
    assign thr_next  = thread_q + 2'd1;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CLR;
            CLR:     state_nxt = FILL;
            FILL:    if (accept && bus.pkt_in_last) state_nxt = RUN;
            RUN:     if (run_exit) state_nxt = DRAIN;
            DRAIN:   if (drain_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: pure decode of the state register, except the FILL write and
    // DRAIN read strobes which must land in the same cycle as the handshake.
    always_comb begin
        mode_c     = 2'b11;
        pipe_rst_c = 1'b1;
        rst_fifo_c = 1'b0;
        case (state)
            CLR:   rst_fifo_c = 1'b1;
            FILL:  if (accept) mode_c = 2'b00;
            RUN: begin
                mode_c     = 2'b10;
                pipe_rst_c = 1'b0;
            end
            DRAIN: if (rd_stb) mode_c = 2'b01;
            default: ;
        endcase
    end

    // Counters, thread pointer and registered status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt   <= 8'd0;
            rd_cnt     <= 8'd0;
            run_cnt    <= '0;
            thread_q   <= 2'd0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            thread_q   <= 2'd0;
            done_q     <= 1'b0;
            // FIFO read data appears one cycle after the read strobe.
            out_vld_q  <= rd_stb;
            out_last_q <= rd_stb && (rd_cnt == 8'd1);
            case (state)
                IDLE: if (bus.start) timeout_q <= 1'b0;
                CLR:  word_cnt <= 8'd0;
                FILL: begin
                    run_cnt <= '0;
                    if (accept && (word_cnt != CAP8)) word_cnt <= word_cnt + 8'd1;
                    if (accept && bus.pkt_in_last)    thread_q <= thr_entry;
                end
                RUN: begin
                    run_cnt <= run_cnt + CNT_W'(1);
                    if (run_lim) timeout_q <= 1'b1;
                    if (run_exit) rd_cnt <= word_cnt;
                    else          thread_q <= thr_next;
                end
                DRAIN: begin
                    if (rd_stb)    rd_cnt <= rd_cnt - 8'd1;
                    if (drain_end) done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.pkt_in_ready  = in_rdy;
    assign bus.pkt_out_valid = out_vld_q;
    assign bus.pkt_out_last  = out_last_q;
    assign bus.mode_code     = mode_c;
    assign bus.thread_IF     = thread_q;
    assign bus.pipe_rst      = pipe_rst_c;
    assign bus.rst_FIFO      = rst_fifo_c;
    assign bus.busy          = (state != IDLE);
    assign bus.done          = done_q;
    assign bus.timeout       = timeout_q;
endmodule

// File: tb/tb_pipeline_seq_ctrl.sv
module tb_pipeline_seq_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Event counters sampled on the falling edge
    int n_wr = 0, n_rd = 0, n_vld = 0, n_last = 0, n_clr = 0;
    logic [1:0] thr_q[$];
    int b_wr, b_rd, b_vld, b_last, b_clr;

    pipeline_seq_ctrl_if bus();

    pipeline_seq_ctrl #(
        .FIFO_CAP      (255),
        .MAX_RUN_CYCLES(16),
        .CNT_W         (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mode_code == 2'b00) n_wr++;
            if (bus.mode_code == 2'b01) n_rd++;
            if (bus.mode_code == 2'b10) thr_q.push_back(bus.thread_IF);
            if (bus.pkt_out_valid) n_vld++;
            if (bus.pkt_out_valid && bus.pkt_out_last) n_last++;
            if (bus.rst_FIFO) n_clr++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_wr = n_wr; b_rd = n_rd; b_vld = n_vld; b_last = n_last; b_clr = n_clr;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int         bad;
        int         base;
        int         s_rd;
        int         s_vld;
        logic [1:0] e;

        rst = 1'b1;
        bus.start = 1'b0; bus.pkt_in_valid = 1'b0; bus.pkt_in_last = 1'b0;
        bus.pkt_out_ready = 1'b1; bus.fifo_depth = 8'd0; bus.thread_halt = 4'h0;
        tick(); tick(); #1;
        chk("rst_mode", bus.mode_code, 3);
        chk("rst_thread", bus.thread_IF, 0);
        chk("rst_pipe_rst", bus.pipe_rst, 1);
        chk("rst_rst_fifo", bus.rst_FIFO, 0);
        chk("rst_in_ready", bus.pkt_in_ready, 0);
        chk("rst_out_valid", bus.pkt_out_valid, 0);
        chk("rst_out_last", bus.pkt_out_last, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_timeout", bus.timeout, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b0;
        tick();

        // Basic job: 3 words, all threads halt after 10 RUN cycles
        snap(); base = thr_q.size();
        bus.start = 1'b1; tick(); bus.start = 1'b0; #1;
        chk("clr_rst_fifo", bus.rst_FIFO, 1);
        chk("clr_mode", bus.mode_code, 3);
        chk("clr_busy", bus.busy, 1);
        tick(); #1;
        chk("fill_ready", bus.pkt_in_ready, 1);
        chk("fill_rst_fifo", bus.rst_FIFO, 0);
        for (int i = 0; i < 3; i++) begin
            bus.pkt_in_valid = 1'b1; bus.pkt_in_last = (i == 2);
            tick();
        end
        bus.pkt_in_valid = 1'b0; bus.pkt_in_last = 1'b0; #1;
        chk("run_mode", bus.mode_code, 2);
        chk("run_pipe_rst", bus.pipe_rst, 0);
        repeat (9) tick();
        bus.thread_halt = 4'hF; tick(); bus.thread_halt = 4'h0; #1;
        chk("drain_read", bus.mode_code, 1);
        chk("drain_pipe_rst", bus.pipe_rst, 1);
        chk("basic_run_cycles", thr_q.size() - base, 10);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            e = 2'(i % 4);
            if (thr_q[base + i] !== e) bad++;
        end
        chk("basic_thr_seq", bad, 0);
        tick(); #1;
        chk("d2_valid", bus.pkt_out_valid, 1);
        chk("d2_last", bus.pkt_out_last, 0);
        tick(); tick(); #1;
        chk("d4_valid", bus.pkt_out_valid, 1);
        chk("d4_last", bus.pkt_out_last, 1);
        chk("d4_mode", bus.mode_code, 3);
        tick(); #1;
        chk("basic_done", bus.done, 1);
        chk("basic_idle", bus.busy, 0);
        chk("basic_timeout", bus.timeout, 0);
        tick(); #1;
        chk("done_pulse", bus.done, 0);
        chk("basic_writes", n_wr - b_wr, 3);
        chk("basic_reads", n_rd - b_rd, 3);
        chk("basic_valids", n_vld - b_vld, 3);
        chk("basic_lasts", n_last - b_last, 1);
        chk("basic_clr", n_clr - b_clr, 1);

        // Backpressure: FIFO full blocks the word until depth drops
        snap();
        bus.start = 1'b1; tick(); bus.start = 1'b0; tick();
        bus.fifo_depth = 8'd255; bus.pkt_in_valid = 1'b1; bus.pkt_in_last = 1'b1; #1;
        chk("bp_ready", bus.pkt_in_ready, 0);
        chk("bp_mode", bus.mode_code, 3);
        repeat (3) tick(); #1;
        chk("bp_hold_ready", bus.pkt_in_ready, 0);
        chk("bp_hold_busy", bus.busy, 1);
        bus.fifo_depth = 8'd254; #1;
        chk("bp_ready_254", bus.pkt_in_ready, 1);
        chk("bp_write", bus.mode_code, 0);
        tick();
        bus.pkt_in_valid = 1'b0; bus.pkt_in_last = 1'b0; bus.fifo_depth = 8'd0;
        bus.thread_halt = 4'hF; #1;
        chk("bp_run", bus.mode_code, 2);
        tick(); bus.thread_halt = 4'h0;
        tick(); tick(); #1;
        chk("bp_done", bus.done, 1);
        chk("bp_writes", n_wr - b_wr, 1);
        chk("bp_valids", n_vld - b_vld, 1);
        chk("bp_lasts", n_last - b_last, 1);

        // Timeout: halts never arrive, RUN lasts exactly 16 cycles
        snap(); base = thr_q.size();
        bus.start = 1'b1; tick(); bus.start = 1'b0; tick();
        bus.pkt_in_valid = 1'b1; bus.pkt_in_last = 1'b1; tick();
        bus.pkt_in_valid = 1'b0; bus.pkt_in_last = 1'b0;
        repeat (15) tick(); #1;
        chk("to_last_run_mode", bus.mode_code, 2);
        chk("to_not_yet", bus.timeout, 0);
        tick(); #1;
        chk("to_set", bus.timeout, 1);
        chk("to_drain", bus.mode_code, 1);
        chk("to_run_cycles", thr_q.size() - base, 16);
        tick(); tick(); #1;
        chk("to_done", bus.done, 1);
        repeat (3) tick(); #1;
        chk("to_sticky", bus.timeout, 1);

        // Rotation with halt=0101 plus a 5-cycle drain stall
        snap(); base = thr_q.size();
        bus.start = 1'b1; #1;
        chk("to_before_start", bus.timeout, 1);
        tick(); bus.start = 1'b0; #1;
        chk("to_cleared", bus.timeout, 0);
        tick();
        bus.thread_halt = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            bus.pkt_in_valid = 1'b1; bus.pkt_in_last = (i == 3);
            tick();
        end
        bus.pkt_in_valid = 1'b0; bus.pkt_in_last = 1'b0;
        repeat (7) tick();
        bus.thread_halt = 4'hF; tick(); bus.thread_halt = 4'h0;
        chk("rot_run_cycles", thr_q.size() - base, 8);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
`ifdef THREAD_SKIP_EN
            e = (i % 2 == 0) ? 2'd1 : 2'd3;
`else
            e = 2'(i % 4);
`endif
            if (thr_q[base + i] !== e) bad++;
        end
        chk("rot_thr_seq", bad, 0);
        tick(); bus.pkt_out_ready = 1'b0; #1;
        chk("stall_mode", bus.mode_code, 3);
        tick();
        s_rd = n_rd; s_vld = n_vld;
        repeat (4) tick();
        chk("stall_no_reads", n_rd - s_rd, 0);
        chk("stall_no_valid", n_vld - s_vld, 0);
        bus.pkt_out_ready = 1'b1;
        for (int k = 0; k < 20 && bus.done !== 1'b1; k++) tick();
        chk("stall_done", bus.done, 1);
        chk("stall_reads", n_rd - b_rd, 4);
        chk("stall_valids", n_vld - b_vld, 4);
        chk("stall_lasts", n_last - b_last, 1);

        // Reset mid-RUN, start ignored while running, then a clean job
        bus.start = 1'b1; tick(); bus.start = 1'b0; tick();
        bus.pkt_in_valid = 1'b1; bus.pkt_in_last = 1'b1; tick();
        bus.pkt_in_valid = 1'b0; bus.pkt_in_last = 1'b0;
        tick(); tick();
        bus.start = 1'b1; tick(); bus.start = 1'b0; #1;
        chk("run_ignores_start", bus.mode_code, 2);
        chk("run_no_clr", bus.rst_FIFO, 0);
        #1 rst = 1'b1;
        #1;
        chk("arst_mode", bus.mode_code, 3);
        chk("arst_pipe_rst", bus.pipe_rst, 1);
        chk("arst_busy", bus.busy, 0);
        chk("arst_thread", bus.thread_IF, 0);
        tick(); rst = 1'b0; tick();
        snap();
        bus.start = 1'b1; tick(); bus.start = 1'b0; #1;
        chk("post_clr", bus.rst_FIFO, 1);
        tick();
        for (int i = 0; i < 2; i++) begin
            bus.pkt_in_valid = 1'b1; bus.pkt_in_last = (i == 1);
            tick();
        end
        bus.pkt_in_valid = 1'b0; bus.pkt_in_last = 1'b0;
        tick();
        bus.thread_halt = 4'hF; tick(); bus.thread_halt = 4'h0;
        for (int k = 0; k < 20 && bus.done !== 1'b1; k++) tick();
        chk("post_done", bus.done, 1);
        chk("post_writes", n_wr - b_wr, 2);
        chk("post_valids", n_vld - b_vld, 2);
        chk("post_lasts", n_last - b_last, 1);
        chk("post_timeout", bus.timeout, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
